// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and load/store.
// Data requests win by default; a saturating streak counter lets a waiting fetch through.
module mem_port_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req_valid,
    input  logic [XLEN-1:0] if_req_addr,
    output logic            if_req_ready,
    input  logic            if_flush,
    output logic            if_resp_valid,
    output logic [XLEN-1:0] if_resp_rdata,
    input  logic            d_req_valid,
    input  logic            d_req_we,
    input  logic [XLEN-1:0] d_req_addr,
    input  logic [XLEN-1:0] d_req_wdata,
    input  logic [3:0]      d_req_wstrb,
    output logic            d_req_ready,
    output logic            d_resp_valid,
    output logic [XLEN-1:0] d_resp_rdata,
    output logic            mem_req_valid,
    output logic            mem_req_we,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [3:0]      mem_req_wstrb,
    input  logic            mem_req_ready,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_rdata,
    output logic            stall_if,
    output logic            stall_mem
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]      state;
    logic [SW-1:0]   streak;
    logic            owner_data;
    logic            drop;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic [3:0]      wstrb_q;

    logic fetch_wins;
    logic grant_if;
    logic grant_d;

    // Readies are gated by reset so every output is 0 while reset is held.
    always_comb begin
        fetch_wins = if_req_valid && (!d_req_valid || streak == STREAK_MAX);
        grant_if   = (state == S_IDLE) && !reset && fetch_wins;
        grant_d    = (state == S_IDLE) && !reset && d_req_valid && !fetch_wins;
    end

    assign if_req_ready  = grant_if;
    assign d_req_ready   = grant_d;
    assign stall_if      = !reset && if_req_valid && !grant_if;
    assign stall_mem     = !reset && d_req_valid && !grant_d;

    assign mem_req_valid = (state == S_ISSUE);
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;

    assign if_resp_valid = (state == S_RESP) && !owner_data && !drop;
    assign d_resp_valid  = (state == S_RESP) && owner_data;
    assign if_resp_rdata = rdata_q;
    assign d_resp_rdata  = rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            streak     <= '0;
            owner_data <= 1'b0;
            drop       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    drop <= 1'b0;
                    if (grant_if) begin
                        owner_data <= 1'b0;
                        we_q       <= 1'b0;
                        addr_q     <= if_req_addr;
                        wdata_q    <= '0;
                        wstrb_q    <= '0;
                        streak     <= '0;
                        state      <= S_ISSUE;
                    end else if (grant_d) begin
                        owner_data <= 1'b1;
                        we_q       <= d_req_we;
                        addr_q     <= d_req_addr;
                        wdata_q    <= d_req_wdata;
                        wstrb_q    <= d_req_we ? d_req_wstrb : 4'b0000;
                        if (!if_req_valid)
                            streak <= '0;
                        else if (streak != STREAK_MAX)
                            streak <= streak + SW'(1);
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (if_flush && !owner_data)
                        drop <= 1'b1;
                    if (mem_req_ready)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (if_flush && !owner_data)
                        drop <= 1'b1;
                    if (mem_resp_valid) begin
                        // Stores report completion only, never memory data.
                        rdata_q <= we_q ? '0 : mem_resp_rdata;
                        state   <= S_RESP;
                    end
                end
                default: begin
                    drop  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter, checked every cycle
// against a transaction-level model of the single shared memory port.
module tb_mem_port_arbiter;

    localparam int MAX = 4;

    logic        clk;
    logic        reset;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_flush;
    logic        if_resp_valid;
    logic [31:0] if_resp_rdata;
    logic        d_req_valid;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        stall_if;
    logic        stall_mem;

    mem_port_arbiter #(.XLEN(32), .MAX_DATA_STREAK(MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int n_cmp = 0;
    int n_mis = 0;

    // Stimulus applied at the next falling edge.
    logic        drv_reset = 1'b1;
    logic        drv_if_v = 1'b0, drv_d_v = 1'b0, drv_d_we = 1'b0, drv_flush = 1'b0;
    logic [31:0] drv_if_addr = '0, drv_d_addr = '0, drv_d_wdata = '0;
    logic [3:0]  drv_d_wstrb = '0;

    // Memory behaviour knobs and state.
    int unsigned mem_ready_pct = 100;
    int unsigned stray_pct = 0;
    int unsigned dmin = 1, dmax = 1;
    logic        fixed_en = 1'b0;
    logic [31:0] fixed_val = '0;
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    // Reference model: at most one transaction record plus the streak count.
    logic        busy = 1'b0, issued = 1'b0, got = 1'b0, dropped = 1'b0, owner_d = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_wstrb = '0;
    int          streak = 0;
    logic        g_f = 1'b0, g_d = 1'b0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (fixed_en) return fixed_val;
        return (a ^ 32'hC0DE_0000) + 32'h11;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic cycle();
        logic mresp, mready;
        logic [31:0] mdata;
        logic e_frdy, e_drdy, e_mv, e_ifr, e_dr, e_sif, e_smem;
        @(negedge clk);
        mresp  = 1'b0;
        mdata  = $urandom;
        mready = ($urandom_range(99) < mem_ready_pct);
        if (drv_reset) begin
            mem_pend = 1'b0;
        end else if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mresp    = 1'b1;
                mdata    = mem_data(mem_addr);
                mem_pend = 1'b0;
            end
        end else if ($urandom_range(99) < stray_pct) begin
            mresp = 1'b1;
        end
        reset = drv_reset;
        if_req_valid = drv_if_v;  if_req_addr = drv_if_addr;  if_flush = drv_flush;
        d_req_valid = drv_d_v;    d_req_we = drv_d_we;        d_req_addr = drv_d_addr;
        d_req_wdata = drv_d_wdata; d_req_wstrb = drv_d_wstrb;
        mem_req_ready = mready;   mem_resp_valid = mresp;     mem_resp_rdata = mdata;
        #1;
        if (drv_reset) begin
            e_frdy = 0; e_drdy = 0; e_mv = 0; e_ifr = 0; e_dr = 0; e_sif = 0; e_smem = 0;
            chk("rst_mem_req_addr", mem_req_addr, 32'h0);
            chk("rst_if_resp_rdata", if_resp_rdata, 32'h0);
            chk("rst_d_resp_rdata", d_resp_rdata, 32'h0);
        end else begin
            e_frdy = !busy && drv_if_v && (!drv_d_v || streak == MAX);
            e_drdy = !busy && drv_d_v && !(drv_if_v && streak == MAX);
            e_mv   = busy && !issued;
            e_ifr  = busy && got && !owner_d && !dropped;
            e_dr   = busy && got && owner_d;
            e_sif  = drv_if_v && !e_frdy;
            e_smem = drv_d_v && !e_drdy;
        end
        chk1("if_req_ready", if_req_ready, e_frdy);
        chk1("d_req_ready", d_req_ready, e_drdy);
        chk1("stall_if", stall_if, e_sif);
        chk1("stall_mem", stall_mem, e_smem);
        chk1("mem_req_valid", mem_req_valid, e_mv);
        chk1("if_resp_valid", if_resp_valid, e_ifr);
        chk1("d_resp_valid", d_resp_valid, e_dr);
        if (e_mv) begin
            chk("mem_req_addr", mem_req_addr, m_addr);
            chk1("mem_req_we", mem_req_we, m_we);
            chk("mem_req_wstrb", {28'b0, mem_req_wstrb}, {28'b0, m_wstrb});
            if (m_we) chk("mem_req_wdata", mem_req_wdata, m_wdata);
        end
        if (e_ifr) chk("if_resp_rdata", if_resp_rdata, m_rdata);
        if (e_dr)  chk("d_resp_rdata", d_resp_rdata, m_rdata);
        g_f = e_frdy;
        g_d = e_drdy;
        // Advance the model across the coming rising edge.
        if (drv_reset) begin
            busy = 0; issued = 0; got = 0; dropped = 0; streak = 0;
        end else if (!busy) begin
            if (e_frdy || e_drdy) begin
                busy = 1; issued = 0; got = 0; dropped = 0; owner_d = e_drdy;
                m_addr  = e_drdy ? drv_d_addr : drv_if_addr;
                m_we    = e_drdy && drv_d_we;
                m_wdata = drv_d_wdata;
                m_wstrb = m_we ? drv_d_wstrb : 4'b0000;
                if (e_frdy || !drv_if_v) streak = 0;
                else if (streak < MAX) streak++;
            end
        end else if (got) begin
            busy = 0;
        end else begin
            if (drv_flush && !owner_d) dropped = 1;
            if (!issued) begin
                if (mready) begin
                    issued   = 1;
                    mem_pend = 1'b1;
                    mem_cnt  = int'($urandom_range(dmax, dmin));
                    mem_addr = m_addr;
                end
            end else if (mresp) begin
                got     = 1;
                m_rdata = m_we ? 32'h0 : mdata;
            end
        end
    endtask

    initial begin : main
        string seq;
        int    lat, cnt;
        logic  stall_seen;

        reset = 1'b1;
        cycle();
        cycle();
        drv_reset = 1'b0;
        cycle();

        // Fetch only: response two cycles after the memory accepts, data 0x13.
        dmin = 2; dmax = 2; fixed_en = 1'b1; fixed_val = 32'h0000_0013;
        drv_if_v = 1'b1; drv_if_addr = 32'h100;
        cycle();
        chk1("t1_accept", if_req_ready, 1'b1);
        drv_if_v = 1'b0;
        lat = -1; cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (if_resp_valid) begin
                if (lat < 0) lat = i;
                cnt++;
                chk("t1_rdata", if_resp_rdata, 32'h13);
            end
        end
        chk("t1_latency", lat, 4);
        chk("t1_pulses", cnt, 1);
        fixed_en = 1'b0;

        // Both requesters always valid: fairness order.
        dmin = 1; dmax = 1;
        drv_if_v = 1'b1; drv_d_v = 1'b1; drv_d_we = 1'b0;
        drv_if_addr = 32'h1000; drv_d_addr = 32'h2000;
        seq = ""; stall_seen = 1'b0;
        for (int i = 0; i < 100 && seq.len() < 10; i++) begin
            cycle();
            if (d_req_ready) begin
                seq = {seq, "D"};
                if (stall_if) stall_seen = 1'b1;
            end
            if (if_req_ready) seq = {seq, "F"};
            if (g_d) drv_d_addr += 4;
            if (g_f) drv_if_addr += 4;
        end
        n_cmp++;
        if (seq != "DDDDFDDDDF") begin
            n_mis++;
            $display("FAIL t2_grant_order: got %s, expected DDDDFDDDDF", seq);
        end
        chk1("t2_stall_if_seen", stall_seen, 1'b1);
        drv_if_v = 1'b0; drv_d_v = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // Store with partial strobes.
        drv_d_v = 1'b1; drv_d_we = 1'b1; drv_d_addr = 32'h200;
        drv_d_wdata = 32'hDEAD_BEEF; drv_d_wstrb = 4'b0011;
        cycle();
        chk1("t3_accept", d_req_ready, 1'b1);
        drv_d_v = 1'b0; drv_d_we = 1'b0;
        cycle();
        chk1("t3_mem_valid", mem_req_valid, 1'b1);
        chk1("t3_mem_we", mem_req_we, 1'b1);
        chk("t3_mem_addr", mem_req_addr, 32'h200);
        chk("t3_mem_wdata", mem_req_wdata, 32'hDEAD_BEEF);
        chk("t3_mem_wstrb", {28'b0, mem_req_wstrb}, 32'h3);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (d_resp_valid) begin
                cnt++;
                chk("t3_store_rdata", d_resp_rdata, 32'h0);
            end
        end
        chk("t3_pulses", cnt, 1);

        // Fetch flushed while waiting for memory.
        dmin = 3; dmax = 3;
        drv_if_v = 1'b1; drv_if_addr = 32'h300;
        cycle();
        drv_if_v = 1'b0;
        cycle();
        drv_flush = 1'b1;
        cycle();
        drv_flush = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (if_resp_valid) cnt++;
        end
        chk("t4_flushed_pulses", cnt, 0);
        chk1("t4_mem_done", mem_pend, 1'b0);
        drv_if_v = 1'b1; drv_if_addr = 32'h304;
        cycle();
        drv_if_v = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (if_resp_valid) begin
                cnt++;
                chk("t4_next_rdata", if_resp_rdata, mem_data(32'h304));
            end
        end
        chk("t4_next_pulses", cnt, 1);

        // Memory back-pressure: held fields, no readies.
        dmin = 1; dmax = 1; mem_ready_pct = 0;
        drv_d_v = 1'b1; drv_d_we = 1'b0; drv_d_addr = 32'h400; drv_d_wstrb = 4'hF;
        drv_if_v = 1'b1; drv_if_addr = 32'h404;
        cycle();
        chk1("t5_accept", d_req_ready, 1'b1);
        drv_d_addr = 32'h408;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk1("t5_mem_valid", mem_req_valid, 1'b1);
            chk("t5_mem_addr", mem_req_addr, 32'h400);
            chk("t5_mem_wstrb", {28'b0, mem_req_wstrb}, 32'h0);
            chk1("t5_if_ready", if_req_ready, 1'b0);
            chk1("t5_d_ready", d_req_ready, 1'b0);
        end
        mem_ready_pct = 100;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (g_f) drv_if_v = 1'b0;
            if (g_d) drv_d_v = 1'b0;
        end

        // Asynchronous reset in the middle of a wait.
        dmin = 3; dmax = 3;
        drv_if_v = 1'b1; drv_if_addr = 32'h500;
        cycle();
        drv_if_v = 1'b0;
        cycle();
        cycle();
        @(posedge clk);
        #2;
        reset = 1'b1; if_req_valid = 1'b1; if_req_addr = 32'h0;
        drv_reset = 1'b1; drv_if_v = 1'b1; drv_if_addr = 32'h0;
        #1;
        chk1("t6_async_mem_valid", mem_req_valid, 1'b0);
        chk1("t6_async_if_ready", if_req_ready, 1'b0);
        chk1("t6_async_stall_if", stall_if, 1'b0);
        chk1("t6_async_if_resp", if_resp_valid, 1'b0);
        chk("t6_async_mem_addr", mem_req_addr, 32'h0);
        cycle();
        cycle();
        drv_reset = 1'b0;
        cycle();
        chk1("t6_accept", if_req_ready, 1'b1);
        drv_if_v = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (if_resp_valid) begin
                cnt++;
                chk("t6_rdata", if_resp_rdata, mem_data(32'h0));
            end
        end
        chk("t6_pulses", cnt, 1);

        // Randomized traffic with back-pressure, stray responses, flushes and resets.
        mem_ready_pct = 70; stray_pct = 10; dmin = 1; dmax = 4;
        for (int i = 0; i < 3000; i++) begin
            if (drv_reset) drv_reset = 1'b0;
            else if ($urandom_range(499) == 0) drv_reset = 1'b1;
            if (g_f || !drv_if_v) begin
                drv_if_v    = ($urandom_range(2) != 0);
                drv_if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (g_d || !drv_d_v) begin
                drv_d_v     = ($urandom_range(2) != 0);
                drv_d_we    = $urandom_range(1) == 1;
                drv_d_addr  = $urandom;
                drv_d_wdata = $urandom;
                drv_d_wstrb = 4'($urandom_range(15));
            end
            drv_flush = ($urandom_range(5) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
